// File: rtl/qpsk_symbol_detector.sv
// QPSK integrate-and-dump detector: sums SPS I/Q samples, hard-decides a
// Gray dibit, flags weak rails, serialises the dibit and counts symbols.
module qpsk_symbol_detector #(
    parameter int SPS    = 4,
    parameter int ACC_W  = 6,
    parameter int THRESH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       sym_start,
    input  logic [3:0] I_in,
    input  logic [3:0] Q_in,
    output logic [1:0] bits_out,
    output logic       bits_valid,
    output logic       low_conf,
    output logic       serial_bit,
    output logic       serial_valid,
    output logic [7:0] sym_cnt
);

    localparam int CNT_W = $clog2(SPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SPS - 1);
    localparam logic [ACC_W:0] THR = (ACC_W + 1)'(THRESH);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t state, state_nxt;

    logic signed [ACC_W-1:0] acc_i, acc_q;
    logic signed [ACC_W-1:0] samp_i, samp_q;
    logic signed [ACC_W-1:0] sum_i, sum_q;
    logic [ACC_W:0] mag_i, mag_q;
    logic [CNT_W-1:0] cnt;
    logic load, add, decide;

    assign samp_i = {{(ACC_W - 4){I_in[3]}}, I_in};
    assign samp_q = {{(ACC_W - 4){Q_in[3]}}, Q_in};
    assign sum_i  = acc_i + samp_i;
    assign sum_q  = acc_q + samp_q;

    // One extra bit so the most negative sum still has a valid magnitude
    assign mag_i = sum_i[ACC_W-1] ? -{sum_i[ACC_W-1], sum_i}
                                  : {1'b0, sum_i};
    assign mag_q = sum_q[ACC_W-1] ? -{sum_q[ACC_W-1], sum_q}
                                  : {1'b0, sum_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (enable && sym_start) state_nxt = ACCUM;
            ACCUM:   state_nxt = ACCUM;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load   = 1'b0;
        add    = 1'b0;
        decide = 1'b0;
        unique case (state)
            IDLE: load = enable && sym_start;
            ACCUM: begin
                if (enable) begin
                    if (sym_start) begin
                        load = 1'b1;
                    end else if (cnt == LAST) begin
                        decide = 1'b1;
                    end else begin
                        add = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_i <= '0;
            acc_q <= '0;
            cnt   <= '0;
        end else if (load) begin
            acc_i <= samp_i;
            acc_q <= samp_q;
            cnt   <= CNT_W'(1);
        end else if (add) begin
            acc_i <= sum_i;
            acc_q <= sum_q;
            cnt   <= cnt + CNT_W'(1);
        end else if (decide) begin
            acc_i <= '0;
            acc_q <= '0;
            cnt   <= '0;
        end
    end

    // Serialiser: I bit alongside bits_valid, Q bit the cycle after
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bits_out     <= 2'b00;
            bits_valid   <= 1'b0;
            low_conf     <= 1'b0;
            serial_bit   <= 1'b0;
            serial_valid <= 1'b0;
            sym_cnt      <= 8'd0;
        end else begin
            bits_valid   <= decide;
            serial_valid <= decide | bits_valid;
            if (decide) begin
                bits_out   <= {sum_i[ACC_W-1], sum_q[ACC_W-1]};
                low_conf   <= (mag_i < THR) || (mag_q < THR);
                serial_bit <= sum_i[ACC_W-1];
                sym_cnt    <= sym_cnt + 8'd1;
            end else if (bits_valid) begin
                serial_bit <= bits_out[0];
            end
        end
    end

endmodule

// File: tb/tb_qpsk_symbol_detector.sv
// Directed bench for qpsk_symbol_detector: hand-computed decisions,
// latency, realign, enable gaps and reset behaviour.
module tb_qpsk_symbol_detector;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       sym_start;
    logic [3:0] I_in;
    logic [3:0] Q_in;
    logic [1:0] bits_out;
    logic       bits_valid;
    logic       low_conf;
    logic       serial_bit;
    logic       serial_valid;
    logic [7:0] sym_cnt;

    int checks = 0;
    int passed = 0;

    qpsk_symbol_detector #(.SPS(4), .ACC_W(6), .THRESH(2)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .sym_start(sym_start),
        .I_in(I_in),
        .Q_in(Q_in),
        .bits_out(bits_out),
        .bits_valid(bits_valid),
        .low_conf(low_conf),
        .serial_bit(serial_bit),
        .serial_valid(serial_valid),
        .sym_cnt(sym_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one sample, let one rising edge pass, settle 1 time unit
    task automatic drive(input logic en, input logic st,
                         input int i, input int q);
        enable    = en;
        sym_start = st;
        I_in      = 4'(i);
        Q_in      = 4'(q);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 1'b1, 3, 3);
        drive(1'b1, 1'b0, 3, 3);
        checks++;
        if ({bits_out, bits_valid, low_conf, serial_bit, serial_valid} !== 6'b0)
            $display("FAIL reset_outs got %b want 000000",
                     {bits_out, bits_valid, low_conf, serial_bit, serial_valid});
        else passed++;
        checks++;
        if (sym_cnt !== 8'd0)
            $display("FAIL reset_symcnt got %0d want 0", sym_cnt);
        else passed++;
        reset = 1'b1;
        drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_clean();
        drive(1'b1, 1'b1, 3, -3);
        drive(1'b1, 1'b0, 3, -3);
        drive(1'b1, 1'b0, 3, -3);
        checks++;
        if (bits_valid !== 1'b0)
            $display("FAIL clean_early got %b want 0", bits_valid);
        else passed++;
        drive(1'b1, 1'b0, 3, -3);
        checks++;
        if (bits_valid !== 1'b1 || bits_out !== 2'b01 || low_conf !== 1'b0)
            $display("FAIL clean_dec got v=%b b=%b lc=%b want v=1 b=01 lc=0",
                     bits_valid, bits_out, low_conf);
        else passed++;
        checks++;
        if (serial_valid !== 1'b1 || serial_bit !== 1'b0)
            $display("FAIL clean_ser0 got sv=%b sb=%b want sv=1 sb=0",
                     serial_valid, serial_bit);
        else passed++;
        checks++;
        if (sym_cnt !== 8'd1)
            $display("FAIL clean_cnt got %0d want 1", sym_cnt);
        else passed++;
        drive(1'b0, 1'b0, 0, 0);
        checks++;
        if (bits_valid !== 1'b0 || serial_valid !== 1'b1 || serial_bit !== 1'b1)
            $display("FAIL clean_ser1 got v=%b sv=%b sb=%b want v=0 sv=1 sb=1",
                     bits_valid, serial_valid, serial_bit);
        else passed++;
        drive(1'b0, 1'b0, 0, 0);
        checks++;
        if (serial_valid !== 1'b0 || serial_bit !== 1'b1)
            $display("FAIL clean_ser_end got sv=%b sb=%b want sv=0 sb=1",
                     serial_valid, serial_bit);
        else passed++;
    endtask

    task automatic test_low_conf();
        drive(1'b1, 1'b1, 1, -2);
        drive(1'b1, 1'b0, -1, -2);
        drive(1'b1, 1'b0, 1, -2);
        drive(1'b1, 1'b0, -1, -2);
        checks++;
        if (bits_valid !== 1'b1 || bits_out !== 2'b01 || low_conf !== 1'b1)
            $display("FAIL lowconf got v=%b b=%b lc=%b want v=1 b=01 lc=1",
                     bits_valid, bits_out, low_conf);
        else passed++;
        checks++;
        if (sym_cnt !== 8'd2)
            $display("FAIL lowconf_cnt got %0d want 2", sym_cnt);
        else passed++;
        drive(1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        int vi [3];
        int vq [3];
        logic [1:0] exp_bits [3];
        int pulse_at [3];
        logic [1:0] got_bits [3];
        int npulse;
        logic [5:0] ser;
        int nser;
        vi = '{-4, 5, -1};
        vq = '{-4, 5, 7};
        exp_bits = '{2'b11, 2'b00, 2'b10};
        npulse = 0;
        ser = '0;
        nser = 0;
        for (int k = 0; k < 14; k++) begin
            if (k < 12)
                drive(1'b1, k == 0, vi[k/4], vq[k/4]);
            else
                drive(1'b0, 1'b0, 0, 0);
            if (bits_valid === 1'b1) begin
                if (npulse < 3) begin
                    pulse_at[npulse] = k;
                    got_bits[npulse] = bits_out;
                end
                npulse++;
            end
            if (serial_valid === 1'b1) begin
                ser = {ser[4:0], serial_bit};
                nser++;
            end
        end
        checks++;
        if (npulse !== 3)
            $display("FAIL b2b_npulse got %0d want 3", npulse);
        else passed++;
        if (npulse == 3) begin
            for (int s = 0; s < 3; s++) begin
                checks++;
                if (pulse_at[s] !== 4 * s + 3 || got_bits[s] !== exp_bits[s])
                    $display("FAIL b2b_sym%0d got at=%0d b=%b want at=%0d b=%b",
                             s, pulse_at[s], got_bits[s], 4 * s + 3, exp_bits[s]);
                else passed++;
            end
        end
        checks++;
        if (nser !== 6 || ser !== 6'b110010)
            $display("FAIL b2b_serial got n=%0d s=%b want n=6 s=110010",
                     nser, ser);
        else passed++;
        checks++;
        if (sym_cnt !== 8'd5)
            $display("FAIL b2b_cnt got %0d want 5", sym_cnt);
        else passed++;
    endtask

    task automatic test_gaps();
        int first;
        first = -1;
        for (int k = 0; k < 9; k++) begin
            if (k == 0)
                drive(1'b1, 1'b1, 3, -3);
            else if (k >= 2 && k <= 4)
                drive(1'b0, 1'b1, -8, 7);
            else if (k <= 6)
                drive(1'b1, 1'b0, 3, -3);
            else
                drive(1'b0, 1'b0, 0, 0);
            if (bits_valid === 1'b1 && first < 0) begin
                first = k;
                checks++;
                if (bits_out !== 2'b01 || low_conf !== 1'b0)
                    $display("FAIL gap_dec got b=%b lc=%b want b=01 lc=0",
                             bits_out, low_conf);
                else passed++;
            end
        end
        checks++;
        if (first !== 6)
            $display("FAIL gap_latency got %0d want 6", first);
        else passed++;
        checks++;
        if (sym_cnt !== 8'd6)
            $display("FAIL gap_cnt got %0d want 6", sym_cnt);
        else passed++;
    endtask

    task automatic test_realign();
        int npulse;
        npulse = 0;
        drive(1'b1, 1'b1, -7, -7);
        drive(1'b1, 1'b0, -7, -7);
        drive(1'b1, 1'b1, -2, 2);
        if (bits_valid === 1'b1) npulse++;
        drive(1'b1, 1'b0, -2, 2);
        if (bits_valid === 1'b1) npulse++;
        drive(1'b1, 1'b0, -2, 2);
        if (bits_valid === 1'b1) npulse++;
        checks++;
        if (npulse !== 0)
            $display("FAIL realign_partial got %0d pulses want 0", npulse);
        else passed++;
        drive(1'b1, 1'b0, -2, 2);
        checks++;
        if (bits_valid !== 1'b1 || bits_out !== 2'b10 || low_conf !== 1'b0)
            $display("FAIL realign_dec got v=%b b=%b lc=%b want v=1 b=10 lc=0",
                     bits_valid, bits_out, low_conf);
        else passed++;
        drive(1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 3, 3);
        drive(1'b1, 1'b0, 3, 3);
        drive(1'b1, 1'b0, 3, 3);
        drive(1'b1, 1'b1, -3, -3);
        checks++;
        if (bits_valid !== 1'b0 || sym_cnt !== 8'd7)
            $display("FAIL realign_last got v=%b cnt=%0d want v=0 cnt=7",
                     bits_valid, sym_cnt);
        else passed++;
        drive(1'b1, 1'b0, -3, -3);
        drive(1'b1, 1'b0, -3, -3);
        drive(1'b1, 1'b0, -3, -3);
        checks++;
        if (bits_valid !== 1'b1 || bits_out !== 2'b11 || sym_cnt !== 8'd8)
            $display("FAIL realign_last_dec got v=%b b=%b cnt=%0d want v=1 b=11 cnt=8",
                     bits_valid, bits_out, sym_cnt);
        else passed++;
        drive(1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid();
        int npulse;
        npulse = 0;
        drive(1'b1, 1'b1, 5, 5);
        drive(1'b1, 1'b0, 5, 5);
        reset = 1'b0;
        #2;
        checks++;
        if ({bits_out, bits_valid, low_conf, serial_bit, serial_valid} !== 6'b0
            || sym_cnt !== 8'd0)
            $display("FAIL rstmid_outs got %b cnt=%0d want 000000 cnt=0",
                     {bits_out, bits_valid, low_conf, serial_bit, serial_valid},
                     sym_cnt);
        else passed++;
        drive(1'b1, 1'b0, 5, 5);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 5, 5);
            if (bits_valid === 1'b1 || serial_valid === 1'b1) npulse++;
        end
        checks++;
        if (npulse !== 0)
            $display("FAIL rstmid_idle got %0d pulses want 0", npulse);
        else passed++;
        drive(1'b1, 1'b1, -5, 6);
        drive(1'b1, 1'b0, -5, 6);
        drive(1'b1, 1'b0, -5, 6);
        drive(1'b1, 1'b0, -5, 6);
        checks++;
        if (bits_valid !== 1'b1 || bits_out !== 2'b10 || sym_cnt !== 8'd1)
            $display("FAIL rstmid_dec got v=%b b=%b cnt=%0d want v=1 b=10 cnt=1",
                     bits_valid, bits_out, sym_cnt);
        else passed++;
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        sym_start = 1'b0;
        I_in      = 4'd0;
        Q_in      = 4'd0;
        #3;
        test_reset();
        test_clean();
        test_low_conf();
        test_back_to_back();
        test_gaps();
        test_realign();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/qpsk_symbol_detector.md
Name: qpsk_symbol_detector

Overview:
- Downstream of the noisy-channel stage; consumes its signed 4-bit I/Q samples.
- Integrate-and-dump over SPS samples per symbol, hard sign decision per rail, outputs a Gray QPSK dibit plus a serialised bit stream.
- Flags low-confidence decisions whose integrated magnitude falls below a threshold.
- Keeps a wrapping count of decided symbols for link-level BER bookkeeping.

Parameters:
- SPS, 4, samples integrated per symbol; legal range 2..16.
- ACC_W, 6, accumulator width; must be >= 4 + ceil(log2(SPS)).
- THRESH, 2, magnitude below which a rail decision is marked low-confidence (unsigned, < 2^(ACC_W-1)).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- enable  in  1  sample-valid; a sample is accepted on a rising edge with enable=1.
- sym_start  in  1  alignment strobe; qualified by enable; marks the current sample as first of a symbol.
- I_in  in  4  signed two's-complement I sample from the channel.
- Q_in  in  4  signed two's-complement Q sample from the channel.
- bits_out  out  2  decided dibit {I_bit, Q_bit}.
- bits_valid  out  1  one-cycle pulse when bits_out updates.
- low_conf  out  1  valid with bits_valid; 1 if either |acc_I| or |acc_Q| < THRESH.
- serial_bit  out  1  serialised decision, I_bit first then Q_bit.
- serial_valid  out  1  high on each of the two cycles carrying serial_bit.
- sym_cnt  out  8  count of decided symbols, wraps 255->0.

Behaviour:
- Reset (async, reset=0): state IDLE; acc_I, acc_Q, sample counter, bits_out, bits_valid, low_conf, serial_bit, serial_valid, sym_cnt all 0. Any in-progress symbol is discarded.
- Sign extension: I_in and Q_in are sign-extended to ACC_W before summing. Accumulation is exact; no saturation is needed given the ACC_W rule.
- IDLE: ignore samples until enable=1 and sym_start=1. On that edge: acc <= sample, cnt <= 1, go ACCUM.
- ACCUM, enable=0: hold all state; outputs other than pulses hold.
- ACCUM, enable=1, sym_start=0:
  - If cnt < SPS-1: acc <= acc + sample, cnt <= cnt + 1.
  - If cnt == SPS-1 (last sample): decide on sum = acc + sample.
    - I_bit = sign(sum_I), Q_bit = sign(sum_Q); a sum of 0 decides 0.
    - bits_out registered; bits_valid = 1 for the next cycle.
    - low_conf = (|sum_I| < THRESH) or (|sum_Q| < THRESH).
    - sym_cnt + 1.
    - acc <= 0, cnt <= 0, stay ACCUM (free-running; the next sample starts the next symbol, no gap).
- ACCUM, enable=1, sym_start=1 (realign):
  - Partial accumulation is discarded with no decision.
  - acc <= sample, cnt <= 1.
  - Exception: if cnt == SPS-1 on that edge, the current sample is taken as the first sample of the new symbol, the old symbol is dropped, and no bits_valid is produced.
- Latency: bits_valid asserts in the clock cycle immediately after the edge accepting the SPS-th sample.
- Serialiser:
  - Cycle of bits_valid: serial_bit = I_bit, serial_valid = 1.
  - Following cycle: serial_bit = Q_bit, serial_valid = 1.
  - serial_valid is otherwise 0; serial_bit holds its last value.
  - SPS >= 2 guarantees the serialiser is free before the next decision, so no overlap handling is needed.
- bits_valid and serial_valid are never asserted while reset is low or in IDLE.

Test Plan:
- Clean symbol: sym_start with SPS=4 samples I=+3, Q=-3 -> one cycle after the 4th edge, bits_out=2'b01, bits_valid=1, low_conf=0; serial 0 then 1; sym_cnt=1.
- Noise-cancelling low-confidence case: I samples +1,-1,+1,-1 (sum 0), Q samples -2 x4 (sum -8) -> bits_out=2'b01, low_conf=1.
- Back-to-back symbols with continuous enable, 3 symbols (I,Q)=(-4,-4),(+5,+5),(-1,+7) -> bits_valid pulses exactly 4 cycles apart; bits 11, 00, 10; sym_cnt=3; serial stream 1,1,0,0,1,0.
- Enable gaps: enable deasserted for 3 cycles between samples 2 and 3 -> same decision as the ungapped case, delayed by 3 cycles.
- Realign: sym_start reasserted on sample 3 of a symbol -> no bits_valid for the partial symbol; the next decision comes one cycle after the 4th sample counted from the realign edge.
- Reset mid-symbol after 2 samples, release, then a full symbol -> all outputs 0 during reset; the block waits in IDLE for sym_start; sym_cnt restarts at 1.
